toggle_window_sched: RTL
========================

Name: toggle_window_sched

Overview:
- Schedules one shared toggle-measurement engine across NUM_LANES serial bit lanes.
- Each requesting lane gets the engine in round-robin order for a programmable window of win_len cycles.
- Over that window the engine counts d-level transitions and reports the count and its even/odd parity.
- Sits in front of the serial-pattern FSMs as their monitoring/qualification controller.

Parameters:
NUM_LANES, 4, number of serial lanes sharing the engine (>=2)
CNT_W, 8, width of the toggle counter (saturating)
WIN_W, 8, width of the window-length configuration

Ports:
clk  in  1  system clock; all logic on its rising edge
reset_n  in  1  synchronous reset, active-low
lane_d  in  NUM_LANES  serial data, one bit per lane
lane_req  in  NUM_LANES  level request per lane for a measurement
win_len  in  WIN_W  window length in compared samples; sampled at grant
grant  out  NUM_LANES  one-hot; lane currently owning the engine
busy  out  1  high in any state other than IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_lane  out  $clog2(NUM_LANES)  lane index of the result
res_count  out  CNT_W  toggles seen, saturating at 2^CNT_W-1
res_even  out  1  1 when the true (unsaturated) toggle count is even

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n. While reset_n=0 at a clk edge:
  - state=IDLE, rr pointer=0.
  - grant=0, busy=0, res_valid=0, res_lane=0, res_count=0, res_even=0.
- States: IDLE, ARM, MEASURE, REPORT.
- IDLE:
  - If any lane_req bit is set, select the first requesting lane at or after the rr pointer (wrapping) and latch sel and win_len. Next state is ARM.
  - With no requests, stay in IDLE.
- ARM, 1 cycle:
  - grant[sel]=1.
  - Sample lane_d[sel] into prev; clear count and parity; load the window counter with the latched win_len.
  - If the latched win_len==0, go directly to REPORT with count=0 and even=1. Otherwise go to MEASURE.
- MEASURE:
  - grant[sel]=1.
  - Each cycle, compare lane_d[sel] with prev. On a mismatch, count increments (holding at its maximum) and parity flips. Then prev is updated and the window counter decrements.
  - After exactly win_len compares, go to REPORT.
- REPORT:
  - grant=0, res_valid=1.
  - res_lane, res_count and res_even hold stable until res_valid && res_ready.
  - On acceptance: rr pointer=(sel+1) mod NUM_LANES, res_valid drops, next state is IDLE.
- Latency: the first MEASURE cycle is 2 cycles after a req is seen in IDLE. res_valid rises on the cycle after the last compare. Total from request to result is win_len+2 cycles.
- res_even is derived from the parity bit, not res_count[0], so it stays correct after saturation.
- lane_req is sampled only in IDLE. Changes during ARM/MEASURE/REPORT are ignored (unless the optional feature is enabled).
- Changes to win_len after the grant are ignored.
- res_ready held permanently high gives one IDLE cycle between back-to-back measurements.
- Round robin: with all lanes requesting continuously, grants go 0,1,2,3,0,...
- Reset mid-operation returns to IDLE immediately and discards any pending result.

Optional Feature:
- Macro TOGGLE_WINDOW_ABORT_EN.
- When defined: if lane_req[sel] drops during ARM or MEASURE, the engine aborts. It returns to IDLE the next cycle with grant=0, produces no result, and advances the rr pointer past sel.
- When undefined: the measurement always completes regardless of lane_req.

Decomposition:
- Shared package toggle_pkg holds:
  - the state typedef enum {IDLE, ARM, MEASURE, REPORT} twc_state_t;
  - a localparam helper for the lane-index width.
- One sub-module, rr_arbiter:
  - inputs: request vector and pointer;
  - outputs: one-hot winner and index;
  - purely combinational.
- The scheduler contains the FSM, counters and result registers.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks with all lane_req high -> grant=0, busy=0, res_valid=0 throughout; first grant is lane 0 after release.
- Single window: lane 2 requests, win_len=6, lane_d[2] driven 0,1,1,0,1,0,0 (ARM sample then 6 compares) -> res_lane=2, res_count=4, res_even=1, with res_valid at request+8 cycles.
- Round robin: all 4 lanes requesting continuously, win_len=2, res_ready=1 -> grant sequence 0,1,2,3,0; each result carries the matching res_lane.
- Saturation/parity: CNT_W=3, win_len=9, lane alternating every cycle -> res_count=7, res_even=0 (9 toggles).
- Backpressure and zero window: win_len=0 -> result on the cycle after ARM with count=0, even=1. Holding res_ready=0 for 5 cycles keeps res_valid and all fields stable and blocks new grants.
- Abort (TOGGLE_WINDOW_ABORT_EN): lane 1 drops lane_req mid-MEASURE with win_len=10 -> grant clears next cycle, no res_valid, next grant goes to lane 2.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and helpers for the toggle-window scheduler.
package toggle_pkg;

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StReport} twc_state_t;

  // Lane-index width, never narrower than one bit.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toggle_window_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NumLanes = 4,
  parameter int unsigned IdxW     = 2
) (
  input  logic [NumLanes-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [NumLanes-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o
);

  logic              found;
  int unsigned       cand;
  logic [IdxW-1:0]   cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NumLanes; off++) begin
      cand     = (32'(ptr_i) + off) % NumLanes;
      cand_idx = IdxW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/toggle_window_sched.sv
// Round-robin scheduler sharing one toggle-count engine across serial lanes.
// Optional abort on request drop is enabled by defining TOGGLE_WINDOW_ABORT_EN.
module toggle_window_sched
  import toggle_pkg::*;
#(
  parameter int unsigned NumLanes = 4,
  parameter int unsigned CntW     = 8,
  parameter int unsigned WinW     = 8,
  localparam int unsigned IdxW    = lane_idx_w(NumLanes)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [NumLanes-1:0] lane_d_i,
  input  logic [NumLanes-1:0] lane_req_i,
  input  logic [WinW-1:0]     win_len_i,
  output logic [NumLanes-1:0] grant_o,
  output logic                busy_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [IdxW-1:0]     res_lane_o,
  output logic [CntW-1:0]     res_count_o,
  output logic                res_even_o
);

  twc_state_t          state_q, state_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic [NumLanes-1:0] sel_oh_q, sel_oh_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [WinW-1:0]     wcnt_q, wcnt_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                prev_q, prev_d;
  logic                even_q, even_d;

  logic [NumLanes-1:0] arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic [IdxW-1:0]     rr_next;
  logic                cur_d;
  logic                abort;

  rr_arbiter #(
    .NumLanes (NumLanes),
    .IdxW     (IdxW)
  ) u_rr_arbiter (
    .req_i (lane_req_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign cur_d   = lane_d_i[sel_q];
  assign rr_next = (sel_q == IdxW'(NumLanes - 1)) ? '0 : sel_q + 1'b1;

`ifdef TOGGLE_WINDOW_ABORT_EN
  assign abort = ~lane_req_i[sel_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sel_oh_d = sel_oh_q;
    rr_d     = rr_q;
    wcnt_d   = wcnt_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    even_d   = even_q;
    case (state_q)
      StIdle: begin
        if (|lane_req_i) begin
          sel_d    = arb_idx;
          sel_oh_d = arb_gnt;
          wcnt_d   = win_len_i;
          state_d  = StArm;
        end
      end
      StArm: begin
        if (abort) begin
          rr_d    = rr_next;
          state_d = StIdle;
        end else begin
          prev_d  = cur_d;
          cnt_d   = '0;
          even_d  = 1'b1;
          state_d = (wcnt_q == '0) ? StReport : StMeasure;
        end
      end
      StMeasure: begin
        if (abort) begin
          rr_d    = rr_next;
          state_d = StIdle;
        end else begin
          // Parity tracks the true count so evenness survives saturation.
          if (cur_d != prev_q) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            even_d = ~even_q;
          end
          prev_d = cur_d;
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == WinW'(1)) state_d = StReport;
        end
      end
      StReport: begin
        if (res_ready_i) begin
          rr_d    = rr_next;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      sel_oh_q <= '0;
      rr_q     <= '0;
      wcnt_q   <= '0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      even_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sel_oh_q <= sel_oh_d;
      rr_q     <= rr_d;
      wcnt_q   <= wcnt_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      even_q   <= even_d;
    end
  end

  always_comb begin
    grant_o     = ((state_q == StArm) || (state_q == StMeasure)) ? sel_oh_q : '0;
    busy_o      = (state_q != StIdle);
    res_valid_o = (state_q == StReport);
    res_lane_o  = sel_q;
    res_count_o = cnt_q;
    res_even_o  = even_q;
  end

endmodule
